mmac_result_drain: RTL and testbench
====================================

MMAC_RESULT_DRAIN -- requirements
Module: mmac_result_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default mmac_pkg::DATA_WIDTH, element width in bits.
REQ-002 SHALL have parameter M_SIZE, default mmac_pkg::M_SIZE, matrix dimension (rows = columns = M_SIZE, M_SIZE >= 2).
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to snapshot the result matrix and stream it out.
REQ-006 SHALL have port result  input  [DATA_WIDTH-1:0] [0:M_SIZE-1][0:M_SIZE-1]  accumulated matrix from the MAC unit.
REQ-007 SHALL have port busy  output  1  high from capture until the last element is accepted.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the element this cycle.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  current element.
REQ-011 SHALL have port out_row  output  $clog2(M_SIZE)  row index of out_data.
REQ-012 SHALL have port out_col  output  $clog2(M_SIZE)  column index of out_data.
REQ-013 SHALL have port out_last  output  1  high with the final element (row M_SIZE-1, col M_SIZE-1).
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final element is accepted.
REQ-015 SHALL have port mac_clear  output  1  clear request to the MAC unit.

Function
REQ-016 SHALL implement two states: IDLE and STREAM.
REQ-017 SHALL, in IDLE with start=1, register the full result matrix into an internal snapshot buffer at that clock edge and enter STREAM.
REQ-018 SHALL assert out_valid in every STREAM cycle, beginning the cycle after capture (capture-to-first-valid latency 1 cycle).
REQ-019 SHALL emit elements in row-major order: (0,0), (0,1) ... (0,M_SIZE-1), (1,0) ... (M_SIZE-1,M_SIZE-1), M_SIZE*M_SIZE transfers total.
REQ-020 SHALL advance to the next element only on a cycle with out_valid=1 and out_ready=1; column wraps from M_SIZE-1 to 0 and increments row.
REQ-021 SHALL hold out_data, out_row, out_col and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL source out_data only from the snapshot; result changes after capture SHALL not affect streamed values.
REQ-023 SHALL, on acceptance of the element with out_last=1, return to IDLE, deassert out_valid and busy the next cycle, and pulse done for exactly that one cycle.
REQ-024 SHALL ignore start while in STREAM, including in the cycle the last element is accepted; a new capture requires start in IDLE.
REQ-025 SHALL accept start in the cycle done is high (back-to-back drain, one IDLE cycle between streams).
REQ-026 SHALL drive busy=1 exactly when state is STREAM.
REQ-027 SHALL drive out_data, out_row, out_col, out_last to 0 while out_valid=0.

Reset
REQ-028 SHALL, with reset=0 at a rising edge, enter IDLE, zero the row/column counters and snapshot buffer, and drive busy, out_valid, out_last, done, mac_clear, out_data, out_row, out_col to 0.
REQ-029 SHALL abort an in-progress stream on reset without pulsing done; out_valid SHALL be 0 the cycle after reset is sampled low.
REQ-030 SHALL give reset priority over start and out_ready in the same cycle.

Configuration
REQ-031 SHALL, when macro MMAC_DRAIN_CLEAR_EN is defined, assert mac_clear for exactly one cycle, the first STREAM cycle after each capture, so the MAC accumulator restarts from zero while the snapshot drains.
REQ-032 SHALL, when MMAC_DRAIN_CLEAR_EN is not defined, tie mac_clear to 0 and leave MAC accumulator control to the system.

Verification (DATA_WIDTH=8, M_SIZE=2)
REQ-033 SHALL cover: result={{1,2},{3,4}}, start 1 cycle, out_ready=1 -> out_data 1,2,3,4 on 4 consecutive cycles, out_last only with 4, done 1 cycle later, busy high 4 cycles.
REQ-034 SHALL cover: out_ready low 3 cycles while presenting element (0,1)=2 -> out_data=2, out_row=0, out_col=1 held stable all 3 cycles; sequence completes unchanged.
REQ-035 SHALL cover: result changed to {{9,9},{9,9}} one cycle after capture -> streamed values remain 1,2,3,4; start pulsed mid-stream -> ignored, exactly 4 transfers.
REQ-036 SHALL cover: reset=0 after 2 accepted elements -> out_valid=0, busy=0 next cycle, no done pulse; subsequent start drains fresh snapshot from (0,0).
REQ-037 SHALL cover: start held high across done -> second stream begins with one IDLE cycle gap, second snapshot captured in the done cycle.
REQ-038 SHALL cover: with MMAC_DRAIN_CLEAR_EN defined, mac_clear=1 exactly in the first STREAM cycle per capture; without it, mac_clear=0 throughout.

Source files
------------

// File: rtl/mmac_result_drain.sv
// mmac_result_drain: snapshots the MAC result matrix on start and streams it
// out row-major over a valid/ready interface, then pulses done.
// Optional feature macro: MMAC_DRAIN_CLEAR_EN -- when defined, mac_clear pulses
// in the first STREAM cycle after each capture; otherwise mac_clear is tied 0.
//
// Handshake: an element transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, out_data/out_row/out_col/
// out_last hold. out_valid never depends combinationally on out_ready.

package mmac_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int M_SIZE     = 2;
endpackage

module mmac_result_drain #(
  parameter int DATA_WIDTH = mmac_pkg::DATA_WIDTH,
  parameter int M_SIZE     = mmac_pkg::M_SIZE,
  localparam int IW        = (M_SIZE > 1) ? $clog2(M_SIZE) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] result [0:M_SIZE-1][0:M_SIZE-1],
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]         out_row,
  output logic [IW-1:0]         out_col,
  output logic                  out_last,
  output logic                  done,
  output logic                  mac_clear,
  output logic                  o_dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(M_SIZE - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_snap [0:M_SIZE-1][0:M_SIZE-1];
  logic [IW-1:0]         r_row;
  logic [IW-1:0]         r_col;
  logic                  r_done;
  logic                  r_clear;

  logic                  w_capture;
  logic                  w_fire;
  logic                  w_at_last;

  // Capture only from IDLE; start is ignored for the whole stream.
  assign w_capture = (r_state == IDLE) && start;
  // A transfer happens whenever we are streaming and downstream is ready.
  assign w_fire    = (r_state == STREAM) && out_ready;
  assign w_at_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

  // State register: reset dominates start and out_ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> STREAM on capture, back on last accepted element.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = STREAM;
        end
      end
      STREAM: begin
        if (w_fire && w_at_last) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Snapshot buffer: whole matrix registered at the capture edge only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < M_SIZE; r++) begin
        for (int c = 0; c < M_SIZE; c++) begin
          r_snap[r][c] <= '0;
        end
      end
    end else if (w_capture) begin
      for (int r = 0; r < M_SIZE; r++) begin
        for (int c = 0; c < M_SIZE; c++) begin
          r_snap[r][c] <= result[r][c];
        end
      end
    end
  end

  // Row/column walk: restart at (0,0) on capture, advance on each transfer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_capture) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_fire) begin
      if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= w_at_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // done pulses in the cycle after the final element is accepted; a reset
  // mid-stream never reaches the final acceptance, so no pulse is produced.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_fire && w_at_last;
    end
  end

`ifdef MMAC_DRAIN_CLEAR_EN
  // mac_clear lands in the first STREAM cycle so the accumulator restarts
  // while the snapshot is still draining.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_clear <= 1'b0;
    end else begin
      r_clear <= w_capture;
    end
  end
`else
  // Accumulator control is left to the system.
  assign r_clear = 1'b0;
`endif

  // Output decode: everything on the data side reads zero outside STREAM.
  always_comb begin
    busy        = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_row     = '0;
    out_col     = '0;
    out_last    = 1'b0;
    done        = r_done;
    mac_clear   = r_clear;
    o_dbg_state = r_state;
    if (r_state == STREAM) begin
      busy      = 1'b1;
      out_valid = 1'b1;
      out_data  = r_snap[r_row][r_col];
      out_row   = r_row;
      out_col   = r_col;
      out_last  = w_at_last;
    end
  end

endmodule

// File: tb/tb_mmac_result_drain.sv
// tb_mmac_result_drain: directed + random stimulus for mmac_result_drain
// (DATA_WIDTH=8, M_SIZE=2). Expected elements are queued from the bench's own
// copy of the result matrix at capture time and retired on each transfer.
// Define MMAC_DRAIN_CLEAR_EN for both RTL and bench to cover mac_clear.

module tb_mmac_result_drain;

  localparam int DW = 8;
  localparam int MS = 2;
  localparam int W  = 1 + 1 + 1 + DW;  // {last, row, col, data}

  // ---------------- clock / reset ----------------
  logic          clock;
  logic          reset;
  logic          start;
  logic          out_ready;
  logic [DW-1:0] res [0:MS-1][0:MS-1];
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [0:0]    out_row;
  logic [0:0]    out_col;
  logic          out_last;
  logic          done;
  logic          mac_clear;
  logic          o_dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mmac_result_drain #(.DATA_WIDTH(DW), .M_SIZE(MS)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .result     (res),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .done       (done),
    .mac_clear  (mac_clear),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;
  logic         m_busy;
  logic         m_done;
  logic         m_clear;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    res[0][0] = a;
    res[0][1] = b;
    res[1][0] = c;
    res[1][1] = d;
  endtask

  // Check this cycle's outputs against the model, advance the model with the
  // inputs currently driven, then move to 1 time unit after the next edge.
  task automatic step();
    logic [W-1:0] e;
    chk("busy",      {31'd0, busy},        {31'd0, m_busy});
    chk("out_valid", {31'd0, out_valid},   {31'd0, m_busy});
    chk("dbg_state", {31'd0, o_dbg_state}, {31'd0, m_busy});
    chk("done",      {31'd0, done},        {31'd0, m_done});
    chk("mac_clear", {31'd0, mac_clear},   {31'd0, m_clear});
    if (m_busy) begin
      if (exp_q.size() == 0) begin
        chk("q_nonempty", exp_q.size(), 1);
      end else begin
        e = exp_q[0];
        chk("out_data", {24'd0, out_data}, {24'd0, e[DW-1:0]});
        chk("out_col",  {31'd0, out_col},  {31'd0, e[DW]});
        chk("out_row",  {31'd0, out_row},  {31'd0, e[DW+1]});
        chk("out_last", {31'd0, out_last}, {31'd0, e[DW+2]});
      end
    end else begin
      chk("idle_data", {24'd0, out_data}, 32'd0);
      chk("idle_rcl",  {29'd0, out_row, out_col, out_last}, 32'd0);
    end

    if (!reset) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_clear = 1'b0;
      exp_q.delete();
    end else if (!m_busy && start) begin
      for (int r = 0; r < MS; r++) begin
        for (int c = 0; c < MS; c++) begin
          exp_q.push_back({(r == MS-1 && c == MS-1), 1'(r), 1'(c), res[r][c]});
        end
      end
      m_busy = 1'b1;
      m_done = 1'b0;
`ifdef MMAC_DRAIN_CLEAR_EN
      m_clear = 1'b1;
`else
      m_clear = 1'b0;
`endif
    end else if (m_busy && out_ready) begin
      m_clear = 1'b0;
      m_done  = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e[DW+2]) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else begin
      m_done  = 1'b0;
      m_clear = 1'b0;
    end

    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_clear = 1'b0;
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    set_res(8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge clock);
    #1;
    // reset state, start asserted during reset must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b1;
    step();

    // basic drain, full throughput
    set_res(8'd1, 8'd2, 8'd3, 8'd4);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    steps(6);

    // backpressure while presenting (0,1)
    start = 1'b1;
    step();
    start = 1'b0;
    step();               // (0,0) accepted
    out_ready = 1'b0;
    steps(3);             // (0,1) held
    out_ready = 1'b1;
    steps(5);

    // snapshot isolation and mid-stream start
    start = 1'b1;
    step();
    start = 1'b0;
    set_res(8'd9, 8'd9, 8'd9, 8'd9);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    steps(4);

    // reset after two accepted elements, then a fresh drain
    set_res(8'd5, 8'd6, 8'd7, 8'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    steps(2);
    set_res(8'd10, 8'd11, 8'd12, 8'd13);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(6);

    // start held across done: back-to-back streams
    set_res(8'd1, 8'd2, 8'd3, 8'd4);
    start = 1'b1;
    step();
    set_res(8'd21, 8'd22, 8'd23, 8'd24);
    steps(4);
    step();               // done cycle, second capture
    start = 1'b0;
    steps(6);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_res(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    steps(6);

    chk("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
